rst_sequencer: RTL and testbench

Reset controller that turns the raw asynchronous reset into NUM_OUT ordered, per-domain reset outputs.
- Each output asserts asynchronously and deasserts synchronously to clk.
- Domains are released one at a time. The sequencer waits for each domain's ready handshake, with a timeout, before releasing the next.
- Sits at the top level and drives the rst inputs of downstream sync-reset and async-reset register banks.
- Also supports a software-requested full re-sequence.

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_sync.sv | 22 ++
 rtl/rst_sequencer.sv | 131 +++++++++++++
 tb/tb_rst_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer slice.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        WAIT_RDY,
        GAP,
        DONE
    } state_t;

    localparam int DEF_NUM_OUT     = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 8;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_CNT_W       = 8;

    // Index width for n domains; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset bridge: chain is set by rst and shifts in 0 per clk.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Releases NUM_OUT reset domains in order, waiting on each domain's ready with a timeout.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic [NUM_OUT-1:0] rdy_in,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               busy,
    output logic               seq_done,
    output logic [NUM_OUT-1:0] err
);

    localparam int IDX_W = idx_w(NUM_OUT);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic [NUM_OUT-1:0] err_q, err_d;
    logic               rst_synced;
    logic               rdy_cur;
    logic               last_idx;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (rst_synced)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HOLD;
            cnt   <= '0;
            idx   <= '0;
            rst_q <= '1;
            err_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            rst_q <= rst_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        rst_d    = rst_q;
        err_d    = err_q;
        rdy_cur  = 1'b0;
        last_idx = (idx == IDX_W'(NUM_OUT - 1));

        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (i == 32'(idx)) rdy_cur = rdy_in[i];
        end

        if (sw_rst_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            err_d   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (rst_synced) begin
                        cnt_d = '0;
                    end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        rst_d[0] = 1'b0;
                        idx_d    = '0;
                        cnt_d    = '0;
                        state_d  = WAIT_RDY;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                WAIT_RDY: begin
                    // Ready takes precedence over a coincident timeout, so err only on a true miss.
                    if (rdy_cur || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        if (!rdy_cur) begin
                            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                                if (i == 32'(idx)) err_d[i] = 1'b1;
                            end
                        end
                        cnt_d   = '0;
                        state_d = last_idx ? DONE : GAP;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        for (int unsigned i = 0; i < NUM_OUT; i++) begin
                            if (i == 32'(idx) + 32'd1) rst_d[i] = 1'b0;
                        end
                        idx_d   = idx + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = WAIT_RDY;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    assign rst_out  = rst_q;
    assign err      = err_q;
    assign busy     = (state != DONE);
    assign seq_done = (state == DONE);

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed and randomized bench; expectations come from a per-domain release/ready timeline model.
module tb_rst_sequencer;

    localparam int N     = 4;
    localparam int SS    = 2;
    localparam int HC    = 16;
    localparam int GC    = 8;
    localparam int TO    = 64;
    localparam int CW    = 8;
    localparam int NEVER = 1000000;
    localparam int FULL  = 320;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] rdy_in = '0;
    logic [N-1:0] rst_out;
    logic [N-1:0] err;
    logic         busy;
    logic         seq_done;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // tr[k]: first edge (in the current numbering) at which rdy_in[k] is high; stays high after.
    int tr[N];
    // Model timeline: release edge, advance edge, timed-out flag per domain.
    int r_m[N];
    int a_m[N];
    bit e_m[N];

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_OUT     (N),
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HC),
        .GAP_CYCLES  (GC),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .rdy_in     (rdy_in),
        .rst_out    (rst_out),
        .busy       (busy),
        .seq_done   (seq_done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int e);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s edge %0d: got %0h want %0h", tag, e, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst_out"}, 32'(rst_out), 32'(4'hF), 0);
        check({tag, "_err"}, 32'(err), 32'h0, 0);
        check({tag, "_busy"}, 32'(busy), 32'h1, 0);
        check({tag, "_done"}, 32'(seq_done), 32'h0, 0);
    endtask

    // Domain 0 is released HOLD edges after the edge counting starts from (base);
    // each domain waits edges r+1..r+TIMEOUT for ready, next release is GAP edges after advance.
    task automatic plan(input int base);
        int start;
        int first;
        for (int k = 0; k < N; k++) begin
            start  = (k == 0) ? base + HC : a_m[k-1] + GC;
            r_m[k] = start;
            first  = (tr[k] > start + 1) ? tr[k] : start + 1;
            if (first <= start + TO) begin
                a_m[k] = first;
                e_m[k] = 1'b0;
            end else begin
                a_m[k] = start + TO;
                e_m[k] = 1'b1;
            end
        end
    endtask

    // Must be entered between a posedge and the following negedge; edge 1 is the next posedge.
    task automatic run_seq(input int base, input int n);
        logic [N-1:0] xr;
        logic [N-1:0] xe;
        plan(base);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) rdy_in[k] = (e >= tr[k]);
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                xr[k] = (e < r_m[k]);
                xe[k] = e_m[k] && (e >= a_m[k]);
            end
            check("rst_out", 32'(rst_out), 32'(xr), e);
            check("err", 32'(err), 32'(xe), e);
            check("seq_done", 32'(seq_done), 32'(e >= a_m[N-1]), e);
            check("busy", 32'(busy), 32'(e < a_m[N-1]), e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_state("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sw_pulse(input string tag);
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state(tag);
        sw_rst_req = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // All domains ready: releases at 18, 27, 36, 45; done after 46.
        tr = '{0, 0, 0, 0};
        run_seq(SS, 80);

        // Domain 1 never ready: err[1] at 91, rst_out[2] at 99.
        do_reset();
        tr = '{0, NEVER, 0, 0};
        run_seq(SS, 130);

        // Software re-sequence from DONE with err set.
        sw_pulse("sw_done");
        tr = '{0, 0, 0, 0};
        run_seq(0, 60);

        // Domain 2 ready exactly on its timeout edge, then one edge too late.
        do_reset();
        tr = '{0, 0, 36 + TO, 0};
        run_seq(SS, 130);
        do_reset();
        tr = '{0, 0, 36 + TO + 1, 0};
        run_seq(SS, 130);

        // Async reset between edges while in the first GAP.
        do_reset();
        tr = '{0, 0, 0, 0};
        run_seq(SS, 22);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_gap");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_seq(SS, 60);

        // Software re-sequence while waiting on domain 2.
        do_reset();
        tr = '{0, 0, NEVER, 0};
        run_seq(SS, 50);
        sw_pulse("sw_wait");
        tr = '{0, 0, 0, 0};
        run_seq(0, 60);

        // Randomized ready arrival times, some domains never ready.
        repeat (6) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                tr[k] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 160));
            end
            run_seq(SS, FULL);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
